// File: rtl/imc_instr_issue.sv
// rtl/imc_instr_issue.sv - IMC instruction issue stage: FIFO buffer plus opcode-timed hold sequencer
//
// Purpose:
//   Buffers host instructions and presents them one at a time on out_instr.
//   Each instruction is held for an opcode-dependent number of cycles so the
//   memory array can complete it. While nothing is pending, the NOP
//   ({MAGIC, zeros}) is driven with out_valid low.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-low reset
//   in_instr     - host instruction
//   in_valid     - in_instr is valid
//   in_ready     - FIFO accepts (not full, not flushing, not in reset)
//   flush        - discard buffered and in-flight instructions
//   stall        - freeze the issue sequencer
//   out_instr    - instruction to the decoder
//   out_valid    - out_instr is a real instruction
//   fifo_count   - FIFO occupancy
//   empty, full  - FIFO status
//   busy         - FIFO non-empty or an instruction is being held
//   issued_count - instructions loaded onto out_instr (wrapping)

module imc_instr_issue #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int MIG_RD_CYC       = 1,
    parameter int MIG_WR_CYC       = 2,
    parameter int MAGIC_CYC        = 1,
    parameter int IMPLY_CYC        = 2,
    parameter int BITWISE_CYC      = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INSTRUCTION_SIZE-1:0]        in_instr,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               flush,
    input  logic                               stall,
    output logic [INSTRUCTION_SIZE-1:0]        out_instr,
    output logic                               out_valid,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               empty,
    output logic                               full,
    output logic                               busy,
    output logic [15:0]                        issued_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Opcode encodings (bits [31:30]).
    localparam logic [1:0] OP_MAJORITY = 2'b00;
    localparam logic [1:0] OP_MAGIC    = 2'b01;
    localparam logic [1:0] OP_IMPLY    = 2'b10;
    localparam logic [1:0] OP_BITWISE  = 2'b11;

    localparam logic [INSTRUCTION_SIZE-1:0] NOP = {OP_MAGIC, {(INSTRUCTION_SIZE-2){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [3:0]                  hold_q, hold_d;
    logic [INSTRUCTION_SIZE-1:0] out_instr_q, out_instr_d;
    logic                        out_valid_q, out_valid_d;
    logic [15:0]                 issued_q, issued_d;
    logic [INSTRUCTION_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic                        do_push;
    logic                        do_load;
    logic [INSTRUCTION_SIZE-1:0] head;

    // Remaining hold cycles after the load cycle itself (H-1).
    function automatic logic [3:0] hold_minus1(input logic [INSTRUCTION_SIZE-1:0] instr);
        logic [3:0] h;
        case (instr[INSTRUCTION_SIZE-1 -: 2])
            OP_MAJORITY: h = instr[INSTRUCTION_SIZE-3] ? 4'(MIG_WR_CYC - 1) : 4'(MIG_RD_CYC - 1);
            OP_MAGIC:    h = 4'(MAGIC_CYC - 1);
            OP_IMPLY:    h = 4'(IMPLY_CYC - 1);
            default:     h = 4'(BITWISE_CYC - 1);
        endcase
        return h;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(FIFO_DEPTH));
    // Deliberately independent of a same-cycle pop to keep the ready path short.
    assign in_ready     = !full && !flush && rst;
    assign busy         = !empty || (state_q == S_HOLD);
    assign out_instr    = out_instr_q;
    assign out_valid    = out_valid_q;
    assign fifo_count   = count_q;
    assign issued_count = issued_q;
    assign head         = mem_q[rd_ptr_q];
    assign do_push      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        hold_d      = hold_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;
        issued_d    = issued_q;
        do_load     = 1'b0;

        if (flush) begin
            state_d     = S_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            hold_d      = '0;
            out_instr_d = NOP;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty && !stall) begin
                        do_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (hold_q != 4'd0) begin
                            hold_d = hold_q - 4'd1;
                        end else if (!empty) begin
                            // Back-to-back issue: no NOP bubble between instructions.
                            do_load = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            out_instr_d = NOP;
                            out_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (do_load) begin
                state_d     = S_HOLD;
                out_instr_d = head;
                out_valid_d = 1'b1;
                hold_d      = hold_minus1(head);
                rd_ptr_d    = rd_ptr_q + PW'(1);
                issued_d    = issued_q + 16'd1;
            end

            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end

            count_d = count_q + CW'(do_push) - CW'(do_load);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            out_instr_q <= NOP;
            out_valid_q <= 1'b0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
            issued_q    <= issued_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
